// File: rtl/bo_pkg.sv
// Shared encodings for the bloco_operativo datapath: operand selects, ALU ops, default width.
package bo_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  // Operand select codes; code 11 means constant 1 on port A and DATA_IN on port B.
  localparam logic [1:0] SEL_X   = 2'b00;
  localparam logic [1:0] SEL_H   = 2'b01;
  localparam logic [1:0] SEL_S   = 2'b10;
  localparam logic [1:0] SEL_ONE = 2'b11;
  localparam logic [1:0] SEL_IN  = 2'b11;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_PASS = 2'b10,
    OP_ZERO = 2'b11
  } alu_op_e;

endpackage

// File: rtl/bo_alu.sv
// Shared combinational ALU: operand muxes plus add/sub/pass/zero with carry/borrow flag.
module bo_alu
  import bo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] h,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       m0,
  input  logic [1:0]       m1,
  input  logic [1:0]       m2,
  output logic [WIDTH-1:0] result,
  output logic             c
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   ext;

  always_comb begin
    op_a = '0;
    unique case (m0)
      SEL_X:   op_a = x;
      SEL_H:   op_a = h;
      SEL_S:   op_a = s;
      SEL_ONE: op_a = {{(WIDTH-1){1'b0}}, 1'b1};
      default: op_a = '0;
    endcase
  end

  always_comb begin
    op_b = '0;
    unique case (m1)
      SEL_X:   op_b = x;
      SEL_H:   op_b = h;
      SEL_S:   op_b = s;
      SEL_IN:  op_b = data_in;
      default: op_b = '0;
    endcase
  end

  // The extra top bit is the carry on add and the borrow (A < B) on subtract.
  always_comb begin
    ext = '0;
    unique case (alu_op_e'(m2))
      OP_ADD:  ext = {1'b0, op_a} + {1'b0, op_b};
      OP_SUB:  ext = {1'b0, op_a} - {1'b0, op_b};
      OP_PASS: ext = {1'b0, op_a};
      OP_ZERO: ext = '0;
      default: ext = '0;
    endcase
  end

  assign result = ext[WIDTH-1:0];
  assign c      = ext[WIDTH];

endmodule

// File: rtl/bloco_operativo.sv
// Operative block: X/H/S registers around a shared ALU, with ZERO, DONE and sticky OVF.
module bloco_operativo
  import bo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             LX,
  input  logic             LH,
  input  logic             LS,
  input  logic             H,
  input  logic [1:0]       M0,
  input  logic [1:0]       M1,
  input  logic [1:0]       M2,
  output logic             ZERO,
  output logic [WIDTH-1:0] RESULT,
  output logic             DONE,
  output logic             OVF
);

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             done_q;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             ovf_set;

  bo_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .x      (x_q),
    .h      (h_q),
    .s      (s_q),
    .data_in(DATA_IN),
    .m0     (M0),
    .m1     (M1),
    .m2     (M2),
    .result (alu_res),
    .c      (alu_c)
  );

  // Flag only counts when the ALU result is actually captured somewhere.
  assign ovf_set = alu_c & (LS | (LH & H));

  always_comb begin
    x_d   = x_q;
    h_d   = h_q;
    s_d   = s_q;
    ovf_d = ovf_q;
    if (LX) x_d = DATA_IN;
    if (LH) h_d = H ? alu_res : DATA_IN;
    if (LS) s_d = alu_res;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (LX) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q    <= '0;
      h_q    <= '0;
      s_q    <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      h_q    <= h_d;
      s_q    <= s_d;
      done_q <= LS;
      ovf_q  <= ovf_d;
    end
  end

  // Decoded from the register, not the ALU, so no combinational path back to the FSM.
  assign ZERO   = (h_q == '0);
  assign RESULT = s_q;
  assign DONE   = done_q;
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_bloco_operativo.sv
// Table-driven bench for bloco_operativo plus hand sequences for asynchronous reset.
module tb_bloco_operativo;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] DATA_IN;
  logic         LX, LH, LS, H;
  logic [1:0]   M0, M1, M2;
  logic         ZERO;
  logic [W-1:0] RESULT;
  logic         DONE;
  logic         OVF;

  int n_vec;
  int n_err;

  bloco_operativo #(
    .WIDTH(W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .DATA_IN(DATA_IN),
    .LX     (LX),
    .LH     (LH),
    .LS     (LS),
    .H      (H),
    .M0     (M0),
    .M1     (M1),
    .M2     (M2),
    .ZERO   (ZERO),
    .RESULT (RESULT),
    .DONE   (DONE),
    .OVF    (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         lx, lh, ls, hs;
    logic [1:0]   m0, m1, m2;
    logic [W-1:0] din;
    logic         ez;
    logic [W-1:0] eres;
    logic         ed, eo;
  } vec_t;

  vec_t tbl[25];

  task automatic check(input string name, input logic ez, input logic [W-1:0] eres,
                       input logic ed, input logic eo);
    n_vec++;
    if (ZERO !== ez || RESULT !== eres || DONE !== ed || OVF !== eo) begin
      n_err++;
      $display("FAIL %s: got ZERO=%b RESULT=%h DONE=%b OVF=%b, want ZERO=%b RESULT=%h DONE=%b OVF=%b",
               name, ZERO, RESULT, DONE, OVF, ez, eres, ed, eo);
    end
  endtask

  task automatic drive(input logic lx, input logic lh, input logic ls, input logic hs,
                       input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] m2,
                       input logic [W-1:0] din);
    LX = lx; LH = lh; LS = ls; H = hs; M0 = m0; M1 = m1; M2 = m2; DATA_IN = din;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    //           lx    lh    ls    hs    m0    m1    m2    din     ez    eres   ed    eo
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h05, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 2'd0, 8'h00, 1'b0, 8'h08, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 8'h08, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd3, 2'd1, 8'h01, 1'b0, 8'h08, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd3, 2'd1, 8'h01, 1'b0, 8'h08, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd3, 2'd1, 8'h01, 1'b1, 8'h08, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'hFF, 1'b1, 8'h08, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd2, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd3, 2'd0, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h02, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd3, 2'd1, 8'h01, 1'b1, 8'hFF, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2'd3, 2'd0, 8'h04, 1'b1, 8'h03, 1'b1, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h02, 1'b1, 8'h03, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h03, 1'b0, 8'h03, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd1, 2'd0, 8'h09, 1'b0, 8'h05, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd2, 8'h00, 1'b0, 8'h09, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd3, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 2'd0, 2'd2, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 2'd3, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 2'd3, 2'd0, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[24] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd3, 2'd0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("reset_state", 1'b1, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].lx, tbl[i].lh, tbl[i].ls, tbl[i].hs, tbl[i].m0, tbl[i].m1, tbl[i].m2,
            tbl[i].din);
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].ez, tbl[i].eres, tbl[i].ed, tbl[i].eo);
    end

    // Build nonzero state (S=1, OVF=1, DONE=1, H=FF) before a mid-cycle reset.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd3, 2'd0, 8'hFF);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd3, 2'd2, 8'hFF);
    @(negedge clk);
    check("pre_reset", 1'b0, 8'h01, 1'b1, 1'b1);

    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 2'd3, 2'd0, 8'h5A);
    #2 rst = 1'b0;
    #1 check("reset_async", 1'b1, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("reset_held", 1'b1, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 2'd2, 8'h00);
    @(negedge clk);
    check("post_release", 1'b1, 8'h01, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00);
    @(negedge clk);
    check("done_drop", 1'b1, 8'h01, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
